// File: rtl/two_bit_seq_generator_pkg.sv
// Shared types and constants for the 2-bit sequence generator.
// State enum, symbol width, LFSR width/taps and default seed.
package two_bit_seq_pkg;

  localparam int SYM_W = 2;
  localparam int LFSR_W = 16;

  // Fibonacci taps 16,14,13,11 as a mask
  // over the right-shifting register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS =
    16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF =
    16'hACE1;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/two_bit_seq_generator_if.sv
// Control/stream bundle of the 2-bit sequence generator.
// master: start/abort/pattern/gap/repeat_cnt out; slave drives the stream.
interface two_bit_seq_if
  import two_bit_seq_pkg::*;
#(
  parameter int PAT_SYMS = 4,
  parameter int GAP_W = 4,
  parameter int RPT_W = 4
);

  logic                    start;
  logic                    abort;
  logic [2*PAT_SYMS-1:0]   pattern;
  logic [GAP_W-1:0]        gap;
  logic [RPT_W-1:0]        repeat_cnt;
  logic [SYM_W-1:0]        data;
  logic                    data_vld;
  logic                    pat_end;
  logic                    busy;
  logic                    done;

  modport master (
    output start, abort, pattern,
    output gap, repeat_cnt,
    input  data, data_vld, pat_end,
    input  busy, done
  );

  modport slave (
    input  start, abort, pattern,
    input  gap, repeat_cnt,
    output data, data_vld, pat_end,
    output busy, done
  );

endinterface

// File: rtl/two_bit_seq_generator_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to SEED.
// Ports: clk, rst_n, en (shift once), sym (low symbol of state).
module seq_gen_lfsr16
  import two_bit_seq_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [SYM_W-1:0] sym
);

  logic [LFSR_W-1:0] q;
  logic              fb;

  assign fb  = ^(q & LFSR_TAPS);
  assign sym = q[SYM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (en) begin
      q <= {fb, q[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/two_bit_seq_generator.sv
// Serialises a pattern onto a 2-bit stream after LFSR filler gaps.
// Ports: clk, rst_n, bus (slave: controls in, data/vld/pat_end/busy/done out).
module two_bit_seq_generator
  import two_bit_seq_pkg::*;
#(
  parameter int PAT_SYMS = 4,
  parameter int GAP_W = 4,
  parameter int RPT_W = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED =
    LFSR_SEED_DEF
) (
  input logic        clk,
  input logic        rst_n,
  two_bit_seq_if.slave bus
);

  localparam int PAT_W = SYM_W * PAT_SYMS;
  localparam int IDX_W =
    (PAT_SYMS > 1) ? $clog2(PAT_SYMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(PAT_SYMS - 1);

  state_t st_q, st_d;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RPT_W-1:0] rpt_in;

  logic [SYM_W-1:0] data_d;
  logic             vld_d;
  logic             pe_d;
  logic             busy_d;
  logic             done_d;

  logic             lfsr_en;
  logic [SYM_W-1:0] fill;
  logic [SYM_W-1:0] syms [PAT_SYMS];
  logic [SYM_W-1:0] sym;

  seq_gen_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .sym   (fill)
  );

  // Symbol 0 is the MSB pair of the pattern.
  always_comb begin
    for (int i = 0; i < PAT_SYMS; i++) begin
      syms[i] =
        pat_q[(PAT_SYMS-1-i)*SYM_W +: SYM_W];
    end
  end

  assign sym = syms[idx_q];

  assign rpt_in =
    (bus.repeat_cnt == '0) ?
    RPT_W'(1) : bus.repeat_cnt;

  always_comb begin
    st_d    = st_q;
    pat_d   = pat_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    rpt_d   = rpt_q;
    idx_d   = idx_q;
    data_d  = '0;
    vld_d   = 1'b0;
    pe_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    lfsr_en = 1'b0;

    unique case (st_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          pat_d  = bus.pattern;
          gap_d  = bus.gap;
          rpt_d  = rpt_in;
          gcnt_d = '0;
          idx_d  = '0;
          st_d   = (bus.gap != '0) ? GAP : SEND;
        end
      end
      GAP: begin
        data_d  = fill;
        vld_d   = 1'b1;
        busy_d  = 1'b1;
        lfsr_en = 1'b1;
        if (gcnt_q == gap_q - GAP_W'(1)) begin
          gcnt_d = '0;
          st_d   = SEND;
        end else begin
          gcnt_d = gcnt_q + GAP_W'(1);
        end
      end
      SEND: begin
        data_d = sym;
        vld_d  = 1'b1;
        busy_d = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          pe_d  = 1'b1;
          idx_d = '0;
          rpt_d = rpt_q - RPT_W'(1);
          if (rpt_q == RPT_W'(1)) begin
            st_d = DONE;
          end else begin
            st_d = (gap_q == '0) ? SEND : GAP;
          end
        end
      end
      DONE: begin
        // busy stays up through the done pulse.
        busy_d = 1'b1;
        done_d = 1'b1;
        st_d   = IDLE;
      end
      default: begin
        st_d = IDLE;
      end
    endcase

    // Abort wins: quiet stream, no done,
    // LFSR frozen where it stands.
    if (bus.abort && st_q != IDLE) begin
      st_d    = IDLE;
      data_d  = '0;
      vld_d   = 1'b0;
      pe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      lfsr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      pat_q  <= '0;
      gap_q  <= '0;
      gcnt_q <= '0;
      rpt_q  <= '0;
      idx_q  <= '0;
    end else begin
      st_q   <= st_d;
      pat_q  <= pat_d;
      gap_q  <= gap_d;
      gcnt_q <= gcnt_d;
      rpt_q  <= rpt_d;
      idx_q  <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data     <= '0;
      bus.data_vld <= 1'b0;
      bus.pat_end  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.data     <= data_d;
      bus.data_vld <= vld_d;
      bus.pat_end  <= pe_d;
      bus.busy     <= busy_d;
      bus.done     <= done_d;
    end
  end

endmodule

// File: tb/tb_two_bit_seq_generator.sv
// Bench for two_bit_seq_generator: queue-based reference model
// with per-cycle compare, directed pins and randomized traffic.
module tb_two_bit_seq_generator;
  import two_bit_seq_pkg::*;

  localparam int P  = 4;
  localparam int GW = 4;
  localparam int RW = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  two_bit_seq_if #(
    .PAT_SYMS (P),
    .GAP_W    (GW),
    .RPT_W    (RW)
  ) bus ();

  two_bit_seq_generator #(
    .PAT_SYMS  (P),
    .GAP_W     (GW),
    .RPT_W     (RW),
    .LFSR_SEED (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: each accepted burst becomes a list of
  // future output cycles; filler is drawn at pop time
  // so an abort leaves the LFSR where it really stopped.
  typedef struct {
    bit         is_gap;
    logic [1:0] d;
    bit         pe;
    bit         dn;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_lfsr = SEED;
  logic [1:0]  e_data = '0;
  logic        e_vld  = 1'b0;
  logic        e_pe   = 1'b0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;

  function automatic logic [15:0]
    lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic load(input logic [7:0] p,
                      input int g, input int rc);
    ent_t e;
    int   r;
    r = (rc == 0) ? 1 : rc;
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < g; j++) begin
        e = '{1'b1, 2'd0, 1'b0, 1'b0};
        q.push_back(e);
      end
      for (int s = 0; s < P; s++) begin
        e = '{1'b0, p[(P-1-s)*2 +: 2],
              (s == P-1), 1'b0};
        q.push_back(e);
      end
    end
    e = '{1'b0, 2'd0, 1'b0, 1'b1};
    q.push_back(e);
  endtask

  initial forever begin
    ent_t e;
    @(posedge clk or negedge rst_n);
    e_data = '0;
    e_vld  = 1'b0;
    e_pe   = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_lfsr = SEED;
    end else if (q.size() == 0) begin
      if (bus.start && !bus.abort) begin
        load(bus.pattern, int'(bus.gap),
             int'(bus.repeat_cnt));
      end
    end else if (bus.abort) begin
      q.delete();
    end else begin
      e = q.pop_front();
      e_busy = 1'b1;
      if (e.dn) begin
        e_done = 1'b1;
      end else begin
        e_vld = 1'b1;
        e_pe  = e.pe;
        if (e.is_gap) begin
          e_data = m_lfsr[1:0];
          m_lfsr = lfsr_next(m_lfsr);
        end else begin
          e_data = e.d;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    chk("data",     bus.data,     e_data);
    chk("data_vld", bus.data_vld, e_vld);
    chk("pat_end",  bus.pat_end,  e_pe);
    chk("busy",     bus.busy,     e_busy);
    chk("done",     bus.done,     e_done);
  end

  logic [1:0] rd  [1:40];
  logic       rv  [1:40];
  logic       rpe [1:40];
  logic       rdn [1:40];
  logic       rb  [1:40];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start sampled at the next edge (N); records
  // outputs after edges N+1..N+n.
  task automatic burst(input logic [7:0] p,
                       input int g, input int rc,
                       input int n, input bit hold);
    bus.pattern    = p;
    bus.gap        = GW'(g);
    bus.repeat_cnt = RW'(rc);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #2;
      rd[k]  = bus.data;
      rv[k]  = bus.data_vld;
      rpe[k] = bus.pat_end;
      rdn[k] = bus.done;
      rb[k]  = bus.busy;
    end
  endtask

  initial begin
    int vc;
    int pc;
    int dc;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pattern    = '0;
    bus.gap        = '0;
    bus.repeat_cnt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld",  bus.data_vld, 0);
    chk("rst_busy", bus.busy,     0);
    chk("rst_done", bus.done,     0);
    chk("rst_data", bus.data,     0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_busy", bus.busy, 0);

    // No gap, single insertion.
    burst(8'b10_11_01_00, 0, 1, 6, 1'b0);
    chk("ng_d1", rd[1], 2);
    chk("ng_d2", rd[2], 3);
    chk("ng_d3", rd[3], 1);
    chk("ng_d4", rd[4], 0);
    chk("ng_b1", rb[1], 1);
    chk("ng_pe3", rpe[3], 0);
    chk("ng_pe4", rpe[4], 1);
    chk("ng_dn4", rdn[4], 0);
    chk("ng_dn5", rdn[5], 1);
    chk("ng_v5", rv[5], 0);
    chk("ng_b5", rb[5], 1);
    chk("ng_b6", rb[6], 0);

    // Gap 3, two insertions; first filler from seed.
    burst(8'h6C, 3, 2, 16, 1'b0);
    vc = 0;
    pc = 0;
    for (int k = 1; k <= 14; k++) begin
      vc += int'(rv[k]);
      pc += int'(rpe[k]);
    end
    chk("gr_vcnt", vc, 14);
    chk("gr_pecnt", pc, 2);
    chk("gr_pe7", rpe[7], 1);
    chk("gr_pe14", rpe[14], 1);
    chk("gr_f1", rd[1], 1);
    chk("gr_f2", rd[2], 0);
    chk("gr_f3", rd[3], 0);
    chk("gr_s4", rd[4], 1);
    chk("gr_v15", rv[15], 0);
    chk("gr_dn15", rdn[15], 1);

    // repeat_cnt 0 acts as 1.
    burst(8'hD2, 1, 0, 8, 1'b0);
    vc = 0;
    dc = 0;
    for (int k = 1; k <= 8; k++) begin
      vc += int'(rv[k]);
      dc += int'(rdn[k]);
    end
    chk("r0_vcnt", vc, 5);
    chk("r0_done", dc, 1);

    // Abort after the second pattern symbol is out.
    bus.pattern    = 8'hE4;
    bus.gap        = GW'(2);
    bus.repeat_cnt = RW'(1);
    bus.start      = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(4);
    chk("ab_vld0", bus.data_vld, 1);
    chk("ab_sym1", bus.data, 2);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    chk("ab_vld", bus.data_vld, 0);
    chk("ab_busy", bus.busy, 0);
    dc = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      dc += int'(bus.done);
    end
    chk("ab_nodone", dc, 0);
    burst(8'h1B, 3, 1, 9, 1'b0);
    vc = 0;
    for (int k = 1; k <= 9; k++) begin
      vc += int'(rv[k]);
    end
    chk("ab_full", vc, 7);

    // Async reset inside a gap.
    burst(8'hA5, 5, 1, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_vld", bus.data_vld, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_data", bus.data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    chk("ar_idle", bus.busy, 0);

    // start held high through a burst.
    burst(8'h9C, 1, 1, 8, 1'b1);
    dc = 0;
    for (int k = 1; k <= 5; k++) begin
      dc += int'(rdn[k]);
    end
    chk("sh_nodn", dc, 0);
    chk("sh_dn6", rdn[6], 1);
    chk("sh_v7", rv[7], 0);
    chk("sh_b7", rb[7], 0);
    chk("sh_v8", rv[8], 1);
    bus.start = 1'b0;
    tick(10);

    // Randomized traffic; inputs churn mid-burst.
    for (int c = 0; c < 2000; c++) begin
      bus.start   = ($urandom_range(0, 2) == 0);
      bus.abort   = ($urandom_range(0, 49) == 0);
      bus.pattern = 8'($urandom);
      bus.gap     = GW'($urandom_range(0, 5));
      bus.repeat_cnt = RW'($urandom_range(0, 3));
      tick(1);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick(40);
    chk("end_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
